// File: rtl/cv32e40p_ft_pkg.sv
// Purpose: shared types and constants for the TMR prefetch recovery controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cv32e40p_ft_pkg;

  // Number of voted signals watched by the recovery controller
  localparam int unsigned FT_NUM_VOTERS = 5;

  // Bit positions inside the voter mismatch vector
  localparam int unsigned ERR_FETCH_VALID = 0;
  localparam int unsigned ERR_FETCH_RDATA = 1;
  localparam int unsigned ERR_INSTR_REQ   = 2;
  localparam int unsigned ERR_INSTR_ADDR  = 3;
  localparam int unsigned ERR_BUSY        = 4;

  // Recovery controller states
  typedef enum logic [1:0] {
    FT_IDLE   = 2'd0,
    FT_FLUSH  = 2'd1,
    FT_SETTLE = 2'd2,
    FT_FATAL  = 2'd3
  } ft_ctrl_state_e;

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// Purpose: saturating up-counter used to log error-event cycles.
// Latency: count reflects inc/clr one cycle after they are sampled.
// Backpressure: none; clr has priority over inc, counter holds at all-ones.
module cv32e40p_ft_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Clear wins over a coincident increment; stop at the all-ones value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cv32e40p_prefetch_ft_ctrl.sv
// Purpose: detects TMR prefetch replica divergence, logs it and resyncs replicas via a re-branch.
// Latency: error seen in cycle t raises stall_o and pf_branch_o in t+1; IDLE/FATAL branches pass through combinationally.
// Backpressure: stall_o holds decode off for 1+SETTLE_CYCLES cycles per attempt; sticky in FATAL until clear_i.
module cv32e40p_prefetch_ft_ctrl
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FT_NUM_VOTERS-1:0] error_voter_i,
  input  logic                     core_branch_i,
  input  logic [31:0]              core_branch_addr_i,
  input  logic [31:0]              resync_addr_i,
  input  logic                     clear_i,
  output logic                     pf_branch_o,
  output logic [31:0]              pf_branch_addr_o,
  output logic                     stall_o,
  output logic [CNT_W-1:0]         err_count_o,
  output logic [FT_NUM_VOTERS-1:0] err_mask_o,
  output logic                     fatal_o,
  output logic                     recovering_o
);

  localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);
  localparam logic [7:0] SETTLE_L    = 8'(SETTLE_CYCLES);

  ft_ctrl_state_e           state_q, state_d;
  logic [3:0]               retry_q, retry_d;
  logic [7:0]               settle_q, settle_d;
  logic [31:0]              resync_q, resync_d;
  logic [FT_NUM_VOTERS-1:0] mask_q;
  logic                     any_err;

  assign any_err = |error_voter_i;

  // Sequencing state: recovery FSM, retry/settle counters and resync target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FT_IDLE;
      retry_q  <= '0;
      settle_q <= '0;
      resync_q <= '0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      resync_q <= resync_d;
    end
  end

  // Next state and branch/stall outputs; core branches pass through unless FLUSH overrides
  always_comb begin
    state_d          = state_q;
    retry_d          = retry_q;
    settle_d         = settle_q;
    resync_d         = resync_q;
    pf_branch_o      = core_branch_i;
    pf_branch_addr_o = core_branch_addr_i;
    stall_o          = 1'b0;

    case (state_q)
      FT_IDLE: begin
        if (any_err) begin
          // A branch in the same cycle already redirects the replicas, so it is the resync point
          state_d  = FT_FLUSH;
          retry_d  = '0;
          resync_d = core_branch_i ? core_branch_addr_i : resync_addr_i;
        end
      end

      FT_FLUSH: begin
        // Errors here are only logged: the re-branch is already in flight
        pf_branch_o = 1'b1;
        stall_o     = 1'b1;
        if (core_branch_i) begin
          resync_d = core_branch_addr_i;
        end else begin
          pf_branch_addr_o = resync_q;
        end
        state_d  = FT_SETTLE;
        settle_d = SETTLE_L;
      end

      FT_SETTLE: begin
        stall_o = 1'b1;
        if (core_branch_i) begin
          resync_d = core_branch_addr_i;
        end
        if (any_err) begin
          if (retry_q < MAX_RETRY_L) begin
            retry_d = retry_q + 4'd1;
            state_d = FT_FLUSH;
          end else begin
            state_d = FT_FATAL;
          end
        end else begin
          settle_d = settle_q - 8'd1;
          if (settle_q <= 8'd1) begin
            state_d = FT_IDLE;
          end
        end
      end

      FT_FATAL: begin
        stall_o = 1'b1;
        if (clear_i) begin
          state_d = FT_IDLE;
        end
      end

      default: begin
        state_d = FT_IDLE;
      end
    endcase
  end

  // Sticky record of which voted signals ever disagreed; clear wins over new flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (clear_i) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_q | error_voter_i;
    end
  end

  cv32e40p_ft_sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (any_err),
    .clr   (clear_i),
    .count (err_count_o)
  );

  assign err_mask_o   = mask_q;
  assign fatal_o      = (state_q == FT_FATAL);
  assign recovering_o = (state_q == FT_FLUSH) || (state_q == FT_SETTLE);

endmodule
